// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 instruction decode with valid/ready
// handshakes, a one-entry skid buffer behind the output register, and a saturating illegal count.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_type,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_count
);
    typedef struct packed {
        logic [8:0]      typ;
        logic            illegal;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] pc;
    } bundle_t;

    bundle_t          dec, out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       op;
    logic [8:0]       t;
    logic             drain, acc;

    always_comb begin
        op = in_instr[6:0];
        t = {op == 7'b1101111, op == 7'b0110111, op == 7'b0010111,
             op == 7'b1100011, op == 7'b0100011, op == 7'b1100111,
             op == 7'b0000011, op == 7'b0010011, op == 7'b0110011};
        dec         = '0;
        dec.typ     = t;
        dec.illegal = ~|t;
        // every immediate format is sign-extended from instr[31]
        dec.imm     = |t[3:1] ? XLEN'($signed(in_instr[31:20]))
                    : t[4]    ? XLEN'($signed({in_instr[31:25], in_instr[11:7]}))
                    : t[5]    ? XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}))
                    : |t[7:6] ? XLEN'($signed({in_instr[31:12], 12'b0}))
                    : t[8]    ? XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}))
                    : '0;
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.funct3  = in_instr[14:12];
        dec.funct7  = in_instr[31:25];
        dec.pc      = in_pc;
    end

    always_comb begin
        drain        = !out_valid_q || out_ready;
        acc          = in_valid && !skid_valid_q && !flush;
        out_valid_d  = !flush && (drain ? (skid_valid_q || acc) : 1'b1);
        out_d        = drain && skid_valid_q ? skid_q : drain && acc ? dec : out_q;
        skid_valid_d = !flush && !drain && (skid_valid_q || acc);
        skid_d       = !drain && acc ? dec : skid_q;
        cnt_d        = acc && dec.illegal && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready      = !skid_valid_q;
    assign out_valid     = out_valid_q;
    assign out_type      = out_q.typ;
    assign out_illegal   = out_q.illegal;
    assign out_imm       = out_q.imm;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_funct3    = out_q.funct3;
    assign out_funct7    = out_q.funct7;
    assign out_pc        = out_q.pc;
    assign illegal_count = cnt_q;
endmodule
